// File: rtl/cpu_ad48_trap_pkg.sv
// Shared constants for the AD48 trap unit: cause codes, CSR map,
// STATUS layout, privilege levels, FSM encoding and STATUS helpers.
package cpu_ad48_trap_pkg;

    // Exception cause codes
    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT  = 4'd3;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

    // CSR addresses
    localparam logic [2:0] CSR_STATUS = 3'd0;
    localparam logic [2:0] CSR_EPC    = 3'd1;
    localparam logic [2:0] CSR_CAUSE  = 3'd2;
    localparam logic [2:0] CSR_IE     = 3'd3;
    localparam logic [2:0] CSR_IP     = 3'd4;

    // STATUS layout: {PIE, PPRIV[1:0], IE, PRIV[1:0]}
    localparam int STATUS_W    = 6;
    localparam int STAT_PRIV   = 0;
    localparam int STAT_IE     = 2;
    localparam int STAT_PPRIV  = 3;
    localparam int STAT_PIE    = 5;

    localparam logic [1:0] PRIV_MACHINE = 2'd3;
    localparam logic [1:0] PRIV_USER    = 2'd0;

    localparam logic [STATUS_W-1:0] STATUS_RESET = 6'h03;

    // FSM encoding
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_REDIR = 1'b1;

    // Trap entry: stack priv/IE into PPRIV/PIE, go to machine, mask IRQs.
    function automatic logic [STATUS_W-1:0] status_enter(
        input logic [STATUS_W-1:0] s
    );
        logic [STATUS_W-1:0] r;
        r                          = s;
        r[STAT_PPRIV+1:STAT_PPRIV] = s[STAT_PRIV+1:STAT_PRIV];
        r[STAT_PIE]                = s[STAT_IE];
        r[STAT_PRIV+1:STAT_PRIV]   = PRIV_MACHINE;
        r[STAT_IE]                 = 1'b0;
        return r;
    endfunction

    // ERET: unstack PPRIV/PIE, leave the stack as user/enabled.
    function automatic logic [STATUS_W-1:0] status_eret(
        input logic [STATUS_W-1:0] s
    );
        logic [STATUS_W-1:0] r;
        r                          = s;
        r[STAT_PRIV+1:STAT_PRIV]   = s[STAT_PPRIV+1:STAT_PPRIV];
        r[STAT_IE]                 = s[STAT_PIE];
        r[STAT_PPRIV+1:STAT_PPRIV] = PRIV_USER;
        r[STAT_PIE]                = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/cpu_ad48_trap_unit_if.sv
// Redirect handshake between the trap unit (master) and fetch (slave).
// Signals: redirect_valid, redirect_ready, redirect_pc[XLEN-1:0].
interface cpu_ad48_trap_unit_if #(
    parameter int XLEN = 48
);
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/cpu_ad48_irq_pend.sv
// IRQ input register, edge detect, IP register and lowest-index
// priority encoder over IP & IE.
// Ports: clk, reset, irq, ie, ip_we/ip_wdata (write-1-to-clear),
//        take/take_idx (line taken), ip, irq_any, irq_idx.
module cpu_ad48_irq_pend #(
    parameter int                   IRQ_LINES = 4,
    parameter logic [IRQ_LINES-1:0] IRQ_EDGE  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_LINES-1:0] irq,
    input  logic [IRQ_LINES-1:0] ie,
    input  logic                 ip_we,
    input  logic [IRQ_LINES-1:0] ip_wdata,
    input  logic                 take,
    input  logic [3:0]           take_idx,
    output logic [IRQ_LINES-1:0] ip,
    output logic                 irq_any,
    output logic [3:0]           irq_idx
);

    logic [IRQ_LINES-1:0] irq_q;
    logic [IRQ_LINES-1:0] edge_q;
    logic [IRQ_LINES-1:0] edge_d;
    logic [IRQ_LINES-1:0] rise;
    logic [IRQ_LINES-1:0] take_oh;
    logic [IRQ_LINES-1:0] clr;
    logic [IRQ_LINES-1:0] pend;

    // Rise is the 0->1 step the registered irq makes at this edge,
    // so edge lines show up in IP on the same cycle as level lines.
    assign rise = irq & ~irq_q;

    always_comb begin
        take_oh = '0;
        for (int i = 0; i < IRQ_LINES; i++) begin
            take_oh[i] = take && (take_idx == 4'(i));
        end
    end

    assign clr    = (ip_we ? ip_wdata : '0) | take_oh;
    // Set beats clear when both happen in one cycle.
    assign edge_d = ((edge_q & ~clr) | rise) & IRQ_EDGE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q  <= '0;
            edge_q <= '0;
        end else begin
            irq_q  <= irq;
            edge_q <= edge_d;
        end
    end

    assign ip   = (irq_q & ~IRQ_EDGE) | edge_q;
    assign pend = ip & ie;

    always_comb begin
        irq_any = |pend;
        irq_idx = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                irq_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_ad48_trap_unit.sv
// AD48 trap/interrupt controller: arbitrates exceptions, ERET and IRQs,
// owns STATUS/EPC/CAUSE/IE/IP and issues redirects over redir (master).
// Other ports: clk, reset, irq, exc_*, irq_ok, irq_pc, eret_valid,
// csr_we/addr/wdata/rdata, flush, priv_mode.
// Optional: define CPU_AD48_TRAP_VECTORED_EN for per-line IRQ vectors.
module cpu_ad48_trap_unit
    import cpu_ad48_trap_pkg::*;
#(
    parameter int                   XLEN        = 48,
    parameter int                   IRQ_LINES   = 4,
    parameter logic [IRQ_LINES-1:0] IRQ_EDGE    = '0,
    parameter logic [XLEN-1:0]      TRAP_VECTOR = 48'd32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_LINES-1:0] irq,
    input  logic                 exc_valid,
    input  logic [3:0]           exc_cause,
    input  logic [XLEN-1:0]      exc_pc,
    input  logic                 irq_ok,
    input  logic [XLEN-1:0]      irq_pc,
    input  logic                 eret_valid,
    input  logic                 csr_we,
    input  logic [2:0]           csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    output logic                 flush,
    output logic [1:0]           priv_mode,
    cpu_ad48_trap_unit_if.master redir
);

    logic [0:0]           state_q;
    logic [STATUS_W-1:0]  status_q;
    logic [XLEN-1:0]      epc_q;
    logic [XLEN-1:0]      cause_q;
    logic [IRQ_LINES-1:0] ie_q;
    logic [IRQ_LINES-1:0] ip;
    logic                 flush_q;
    logic [XLEN-1:0]      rpc_q;

    logic                 irq_any;
    logic [3:0]           irq_idx;
    logic [XLEN-1:0]      irq_vec;

    logic                 in_run;
    logic                 ev_exc;
    logic                 ev_eret;
    logic                 ev_irq;
    logic                 accept;
    logic                 csr_wr;

    assign in_run  = (state_q == S_RUN);
    assign ev_exc  = in_run && exc_valid;
    assign ev_eret = in_run && !exc_valid && eret_valid;
    assign ev_irq  = in_run && !exc_valid && !eret_valid
                  && status_q[STAT_IE] && irq_ok && irq_any;
    assign accept  = ev_exc || ev_eret || ev_irq;

    // A CSR write racing a trap or ERET loses.
    assign csr_wr  = csr_we && !accept;

    cpu_ad48_irq_pend #(
        .IRQ_LINES (IRQ_LINES),
        .IRQ_EDGE  (IRQ_EDGE)
    ) u_pend (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .ie       (ie_q),
        .ip_we    (csr_wr && (csr_addr == CSR_IP)),
        .ip_wdata (csr_wdata[IRQ_LINES-1:0]),
        .take     (ev_irq),
        .take_idx (irq_idx),
        .ip       (ip),
        .irq_any  (irq_any),
        .irq_idx  (irq_idx)
    );

`ifdef CPU_AD48_TRAP_VECTORED_EN
    assign irq_vec = TRAP_VECTOR + XLEN'(1) + XLEN'(irq_idx);
`else
    assign irq_vec = TRAP_VECTOR;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            status_q <= STATUS_RESET;
            epc_q    <= '0;
            cause_q  <= '0;
            ie_q     <= '0;
            flush_q  <= 1'b0;
            rpc_q    <= '0;
        end else begin
            flush_q <= accept;

            unique case (state_q)
                S_RUN: begin
                    if (accept) begin
                        state_q <= S_REDIR;
                    end
                end
                S_REDIR: begin
                    if (redir.redirect_ready) begin
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase

            if (ev_exc) begin
                epc_q    <= exc_pc;
                cause_q  <= XLEN'(exc_cause);
                status_q <= status_enter(status_q);
                rpc_q    <= TRAP_VECTOR;
            end else if (ev_eret) begin
                status_q <= status_eret(status_q);
                rpc_q    <= epc_q;
            end else if (ev_irq) begin
                epc_q    <= irq_pc;
                cause_q  <= {1'b1, (XLEN-1)'(irq_idx)};
                status_q <= status_enter(status_q);
                rpc_q    <= irq_vec;
            end else if (csr_wr) begin
                case (csr_addr)
                    CSR_STATUS: status_q <= csr_wdata[STATUS_W-1:0];
                    CSR_EPC:    epc_q    <= csr_wdata;
                    CSR_CAUSE:  cause_q  <= csr_wdata;
                    CSR_IE:     ie_q     <= csr_wdata[IRQ_LINES-1:0];
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_STATUS: csr_rdata = XLEN'(status_q);
            CSR_EPC:    csr_rdata = epc_q;
            CSR_CAUSE:  csr_rdata = cause_q;
            CSR_IE:     csr_rdata = XLEN'(ie_q);
            CSR_IP:     csr_rdata = XLEN'(ip);
            default:    csr_rdata = '0;
        endcase
    end

    assign flush                = flush_q;
    assign priv_mode            = status_q[STAT_PRIV+1:STAT_PRIV];
    assign redir.redirect_valid = (state_q == S_REDIR);
    assign redir.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_cpu_ad48_trap_unit.sv
// Directed bench for cpu_ad48_trap_unit: exceptions, level/edge IRQs,
// priority, ERET, stalled redirect and asynchronous reset.
module tb_cpu_ad48_trap_unit;

    localparam logic [47:0] IRQ_BIT = 48'h8000_0000_0000;
`ifdef CPU_AD48_TRAP_VECTORED_EN
    localparam logic [47:0] VEC_L1 = 48'd34;
    localparam logic [47:0] VEC_L3 = 48'd36;
`else
    localparam logic [47:0] VEC_L1 = 48'd32;
    localparam logic [47:0] VEC_L3 = 48'd32;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [47:0] exc_pc;
    logic        irq_ok;
    logic [47:0] irq_pc;
    logic        eret_valid;
    logic        csr_we;
    logic [2:0]  csr_addr;
    logic [47:0] csr_wdata;
    logic [47:0] csr_rdata;
    logic        flush;
    logic [1:0]  priv_mode;

    int checks   = 0;
    int failures = 0;

    cpu_ad48_trap_unit_if #(.XLEN(48)) redir ();

    cpu_ad48_trap_unit #(
        .XLEN        (48),
        .IRQ_LINES   (4),
        .IRQ_EDGE    (4'b1000),
        .TRAP_VECTOR (48'd32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_pc     (exc_pc),
        .irq_ok     (irq_ok),
        .irq_pc     (irq_pc),
        .eret_valid (eret_valid),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .flush      (flush),
        .priv_mode  (priv_mode),
        .redir      (redir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got,
                         input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [47:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [47:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic chk_csr(input string tag, input logic [2:0] a,
                           input logic [47:0] exp);
        logic [47:0] d;
        csr_rd(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        reset      = 1'b1;
        irq        = '0;
        exc_valid  = 1'b0;
        exc_cause  = '0;
        exc_pc     = '0;
        irq_ok     = 1'b0;
        irq_pc     = '0;
        eret_valid = 1'b0;
        csr_we     = 1'b0;
        csr_addr   = '0;
        csr_wdata  = '0;
        redir.redirect_ready = 1'b1;

        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Reset state
        check("rst_priv", 48'(priv_mode), 48'd3);
        check("rst_flush", 48'(flush), 48'd0);
        check("rst_rv", 48'(redir.redirect_valid), 48'd0);
        check("rst_rpc", redir.redirect_pc, 48'd0);
        chk_csr("rst_status", 3'd0, 48'h3);
        chk_csr("rst_epc", 3'd1, 48'd0);
        chk_csr("rst_cause", 3'd2, 48'd0);
        chk_csr("rst_ie", 3'd3, 48'd0);
        chk_csr("rst_ip", 3'd4, 48'd0);
        chk_csr("unmapped", 3'd7, 48'd0);
        tick();

        // Illegal instruction
        exc_valid = 1'b1;
        exc_cause = 4'd2;
        exc_pc    = 48'd5;
        tick();
        exc_valid = 1'b0;
        check("ill_flush", 48'(flush), 48'd1);
        check("ill_rv", 48'(redir.redirect_valid), 48'd1);
        check("ill_rpc", redir.redirect_pc, 48'd32);
        check("ill_priv", 48'(priv_mode), 48'd3);
        chk_csr("ill_epc", 3'd1, 48'd5);
        chk_csr("ill_cause", 3'd2, 48'd2);
        chk_csr("ill_status", 3'd0, 48'h1B);
        tick();
        check("ill_flush_end", 48'(flush), 48'd0);
        check("ill_rv_end", 48'(redir.redirect_valid), 48'd0);

        // Level IRQ on lines 1 and 2; line 1 wins
        csr_wr(3'd3, 48'b0110);
        csr_wr(3'd0, 48'h7);
        chk_csr("lvl_ie", 3'd3, 48'b0110);
        irq    = 4'b0110;
        irq_ok = 1'b1;
        irq_pc = 48'd9;
        tick();
        chk_csr("lvl_ip", 3'd4, 48'b0110);
        tick();
        irq    = '0;
        irq_ok = 1'b0;
        check("lvl_flush", 48'(flush), 48'd1);
        check("lvl_rpc", redir.redirect_pc, VEC_L1);
        chk_csr("lvl_epc", 3'd1, 48'd9);
        chk_csr("lvl_cause", 3'd2, IRQ_BIT | 48'd1);
        chk_csr("lvl_status", 3'd0, 48'h3B);
        tick();
        eret_valid = 1'b1;
        tick();
        eret_valid = 1'b0;
        check("eret1_rpc", redir.redirect_pc, 48'd9);
        check("eret1_flush", 48'(flush), 48'd1);
        chk_csr("eret1_status", 3'd0, 48'h27);

        // Exception beats IRQ; IRQ follows after ERET
        irq = 4'b0010;
        tick();
        exc_valid = 1'b1;
        exc_cause = 4'd4;
        exc_pc    = 48'd20;
        irq_ok    = 1'b1;
        irq_pc    = 48'd21;
        tick();
        exc_valid = 1'b0;
        chk_csr("pri_cause", 3'd2, 48'd4);
        chk_csr("pri_epc", 3'd1, 48'd20);
        check("pri_rpc", redir.redirect_pc, 48'd32);
        tick();
        eret_valid = 1'b1;
        tick();
        eret_valid = 1'b0;
        check("pri_eret_rpc", redir.redirect_pc, 48'd20);
        chk_csr("pri_eret_status", 3'd0, 48'h27);
        tick();
        check("pri_redir_flush", 48'(flush), 48'd0);
        check("pri_redir_rv", 48'(redir.redirect_valid), 48'd0);
        tick();
        irq    = '0;
        irq_ok = 1'b0;
        check("pri_irq_flush", 48'(flush), 48'd1);
        check("pri_irq_rpc", redir.redirect_pc, VEC_L1);
        chk_csr("pri_irq_cause", 3'd2, IRQ_BIT | 48'd1);
        chk_csr("pri_irq_epc", 3'd1, 48'd21);

        // Edge line 3
        irq = 4'b1000;
        tick();
        irq = '0;
        chk_csr("edge_ip_set", 3'd4, 48'b1000);
        tick();
        chk_csr("edge_ip_hold", 3'd4, 48'b1000);
        csr_wr(3'd4, 48'b1000);
        chk_csr("edge_ip_clr", 3'd4, 48'd0);
        irq = 4'b1000;
        tick();
        irq = '0;
        tick();
        chk_csr("edge_ip_again", 3'd4, 48'b1000);
        csr_wr(3'd3, 48'b1000);
        csr_wr(3'd0, 48'h7);
        irq_ok = 1'b1;
        irq_pc = 48'd40;
        tick();
        irq_ok = 1'b0;
        check("edge_flush", 48'(flush), 48'd1);
        check("edge_rpc", redir.redirect_pc, VEC_L3);
        chk_csr("edge_cause", 3'd2, IRQ_BIT | 48'd3);
        chk_csr("edge_epc", 3'd1, 48'd40);
        chk_csr("edge_ip_auto", 3'd4, 48'd0);
        tick();

        // Stalled redirect
        redir.redirect_ready = 1'b0;
        exc_valid = 1'b1;
        exc_cause = 4'd6;
        exc_pc    = 48'd50;
        tick();
        exc_cause = 4'd3;
        exc_pc    = 48'd60;
        for (int i = 0; i < 3; i++) begin
            check("stall_rv", 48'(redir.redirect_valid), 48'd1);
            check("stall_rpc", redir.redirect_pc, 48'd32);
            chk_csr("stall_epc", 3'd1, 48'd50);
            chk_csr("stall_cause", 3'd2, 48'd6);
            tick();
        end
        exc_valid = 1'b0;
        redir.redirect_ready = 1'b1;
        tick();
        check("stall_rv_end", 48'(redir.redirect_valid), 48'd0);
        check("stall_flush", 48'(flush), 48'd0);

        // Async reset in REDIR
        redir.redirect_ready = 1'b0;
        exc_valid = 1'b1;
        exc_cause = 4'd2;
        exc_pc    = 48'd70;
        tick();
        exc_valid = 1'b0;
        check("ar_rv_pre", 48'(redir.redirect_valid), 48'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_rv", 48'(redir.redirect_valid), 48'd0);
        check("ar_priv", 48'(priv_mode), 48'd3);
        check("ar_flush", 48'(flush), 48'd0);
        #2 reset = 1'b0;
        redir.redirect_ready = 1'b1;
        tick();
        chk_csr("ar_epc", 3'd1, 48'd0);
        chk_csr("ar_status", 3'd0, 48'h3);
        exc_valid = 1'b1;
        exc_pc    = 48'd3;
        tick();
        exc_valid = 1'b0;
        check("ar_run_rv", 48'(redir.redirect_valid), 48'd1);
        chk_csr("ar_run_epc", 3'd1, 48'd3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
